// File: rtl/m1of4_dcnt_pkg.sv
// Shared definitions for the 1-of-4 coded down-counter: digit codes, FSM state and digit type.
package m1of4_dcnt_pkg;

  typedef logic [3:0] dig_t;

  localparam dig_t C0 = 4'b0001;
  localparam dig_t C1 = 4'b0010;
  localparam dig_t C2 = 4'b0100;
  localparam dig_t C3 = 4'b1000;

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic logic is_1of4(input dig_t d);
    return (d == C0) || (d == C1) || (d == C2) || (d == C3);
  endfunction

endpackage

// File: rtl/m1of4_dcnt_dig.sv
// One 1-of-4 digit: rotate-down when borrowed into, propagate borrow when at zero,
// plus a one-hot validity check on an incoming load digit.
module m1of4_dig
  import m1of4_dcnt_pkg::*;
(
  input  dig_t dig_i,
  input  logic bin_i,
  input  dig_t chk_i,
  output dig_t dig_o,
  output logic bout_o,
  output logic ok_o
);

  // Rotating right maps value i to i-1 and wraps 0 back to 3.
  assign dig_o  = bin_i ? {dig_i[0], dig_i[3:1]} : dig_i;
  assign bout_o = bin_i && (dig_i == C0);
  assign ok_o   = is_1of4(chk_i);

endmodule

// File: rtl/m1of4_dcnt.sv
// DW-digit base-4 down-counter with 1-of-4 coded digits and load/release handshake.
// Optional load code check enabled by defining M1OF4_CODE_CHK_EN.
module m1of4_dcnt
  import m1of4_dcnt_pkg::*;
#(
  parameter int DW   = 4,
  parameter int WRAP = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_vld,
  output logic          ld_rdy,
  input  logic [4*DW-1:0] ld_d,
  input  logic          dec,
  input  logic          rel,
  output logic [4*DW-1:0] d_o,
  output logic          zero,
  output logic          nzero,
  output logic          uflow,
  output logic          err
);

  state_t          state_q;
  logic [4*DW-1:0] d_q;
  logic            uflow_q;
  logic            err_q;

  logic [DW:0]     brw;
  logic [DW-1:0]   ok;
  logic [4*DW-1:0] d_d;
  logic            ld_ok;
  logic            zero_all;

  // Borrow chain: digit 0 always sees the request, higher digits only when all lower are zero.
  assign brw[0] = dec && !rel && (state_q == ACTIVE);

  for (genvar k = 0; k < DW; k++) begin : g_dig
    m1of4_dig u_dig (
      .dig_i (d_q[4*k +: 4]),
      .bin_i (brw[k]),
      .chk_i (ld_d[4*k +: 4]),
      .dig_o (d_d[4*k +: 4]),
      .bout_o(brw[k+1]),
      .ok_o  (ok[k])
    );
  end

`ifdef M1OF4_CODE_CHK_EN
  assign ld_ok = &ok;
`else
  logic unused_ok;
  assign unused_ok = &ok;
  assign ld_ok     = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      d_q     <= '0;
      uflow_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      uflow_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        EMPTY: begin
          if (ld_vld) begin
            if (ld_ok) begin
              state_q <= ACTIVE;
              d_q     <= ld_d;
            end else begin
              err_q   <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (rel) begin
            state_q <= EMPTY;
            d_q     <= '0;
          end else if (dec) begin
            uflow_q <= brw[DW];
            // Borrow out of the top digit means the count was zero.
            if (!(brw[DW] && WRAP == 0)) d_q <= d_d;
          end
        end
        default: begin
          state_q <= EMPTY;
          d_q     <= '0;
        end
      endcase
    end
  end

  assign zero_all = (d_q == {DW{C0}});
  assign ld_rdy   = (state_q == EMPTY);
  assign d_o      = d_q;
  assign zero     = (state_q == ACTIVE) && zero_all;
  assign nzero    = (state_q == ACTIVE) && !zero_all;
  assign uflow    = uflow_q;
  assign err      = err_q;

endmodule

// File: tb/tb_m1of4_dcnt.sv
// Directed bench for m1of4_dcnt: DW=2 instances with WRAP=0 (u0) and WRAP=1 (u1) on shared stimulus.
module tb_m1of4_dcnt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_vld, dec, rel;
  logic [7:0] ld_d;

  logic       rdy0, rdy1, z0, z1, nz0, nz1, uf0, uf1, er0, er1;
  logic [7:0] d0, d1;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  m1of4_dcnt #(.DW(2), .WRAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .ld_vld(ld_vld), .ld_rdy(rdy0), .ld_d(ld_d),
    .dec(dec), .rel(rel), .d_o(d0), .zero(z0), .nzero(nz0), .uflow(uf0), .err(er0)
  );

  m1of4_dcnt #(.DW(2), .WRAP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ld_vld(ld_vld), .ld_rdy(rdy1), .ld_d(ld_d),
    .dec(dec), .rel(rel), .d_o(d1), .zero(z1), .nzero(nz1), .uflow(uf1), .err(er1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // flags: {ld_rdy, zero, nzero, uflow, err}
  task automatic chk0(input string tag, input logic [7:0] d, input logic [4:0] f);
    chk({tag, " u0.d"}, d0, d);
    chk({tag, " u0.flags"}, {3'b0, rdy0, z0, nz0, uf0, er0}, {3'b0, f});
  endtask

  task automatic chk1(input string tag, input logic [7:0] d, input logic [4:0] f);
    chk({tag, " u1.d"}, d1, d);
    chk({tag, " u1.flags"}, {3'b0, rdy1, z1, nz1, uf1, er1}, {3'b0, f});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ld_vld = 1'b0; dec = 1'b0; rel = 1'b0; ld_d = 8'h00;
    #12;
    chk0("reset", 8'h00, 5'b10000);
    chk1("reset", 8'h00, 5'b10000);
    rst_n = 1'b1;

    // dec/rel ignored while EMPTY
    dec = 1'b1; rel = 1'b1; step();
    chk0("empty_ign", 8'h00, 5'b10000);
    dec = 1'b0; rel = 1'b0;

    // load {C2,C1} = 9, then two decrements
    ld_vld = 1'b1; ld_d = 8'h42; step();
    ld_vld = 1'b0;
    chk0("load9", 8'h42, 5'b00100);
    chk1("load9", 8'h42, 5'b00100);
    dec = 1'b1; step();
    chk0("dec8", 8'h41, 5'b00100);
    step();
    chk0("dec7", 8'h28, 5'b00100);
    chk1("dec7", 8'h28, 5'b00100);

    // release
    dec = 1'b0; rel = 1'b1; step();
    rel = 1'b0;
    chk0("rel", 8'h00, 5'b10000);

    // load {C0,C1} = 1, decrement to zero then underflow
    ld_vld = 1'b1; ld_d = 8'h12; step();
    ld_vld = 1'b0; dec = 1'b1; step();
    chk0("dec_to0", 8'h11, 5'b01000);
    chk1("dec_to0", 8'h11, 5'b01000);
    step();
    chk0("uflow_sat", 8'h11, 5'b01010);
    chk1("uflow_wrap", 8'h88, 5'b00110);
    dec = 1'b0; step();
    chk0("uflow_1cyc", 8'h11, 5'b01000);
    chk1("uflow_1cyc", 8'h88, 5'b00100);

    // load {C0,C0} directly then dec
    rel = 1'b1; step();
    rel = 1'b0; ld_vld = 1'b1; ld_d = 8'h11; step();
    ld_vld = 1'b0; dec = 1'b1; step();
    dec = 1'b0;
    chk0("z_dec_sat", 8'h11, 5'b01010);
    chk1("z_dec_wrap", 8'h88, 5'b00110);

    // rel beats dec, u0 is at zero so a uflow here would be wrong
    dec = 1'b1; rel = 1'b1; step();
    dec = 1'b0; rel = 1'b0;
    chk0("rel_prio", 8'h00, 5'b10000);
    chk1("rel_prio", 8'h00, 5'b10000);

    // load while ACTIVE is not accepted
    ld_vld = 1'b1; ld_d = 8'h48; step();
    ld_d = 8'h22; step();
    ld_vld = 1'b0;
    chk0("ld_busy", 8'h48, 5'b00100);

    // async reset mid-count, checked before the next edge
    dec = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk0("async_rst", 8'h00, 5'b10000);
    chk1("async_rst", 8'h00, 5'b10000);
    step();
    #3 rst_n = 1'b1;
    dec = 1'b0;
    step();
    chk0("rst_exit", 8'h00, 5'b10000);

    // malformed digit 4'b0110
    ld_vld = 1'b1; ld_d = 8'h16; step();
    ld_vld = 1'b0;
`ifdef M1OF4_CODE_CHK_EN
    chk0("bad_code", 8'h00, 5'b10001);
    step();
    chk0("err_1cyc", 8'h00, 5'b10000);
`else
    chk("err_tied0", {7'b0, er0}, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/m1of4_dcnt.md
M1OF4_DCNT -- requirements
Module: m1of4_dcnt

Interface
REQ-001 SHALL have parameter DW, default 4: number of 1-of-4 coded digits (base-4), DW >= 1.
REQ-002 SHALL have parameter WRAP, default 0: 0 means saturate at zero; 1 means wrap from zero to all digits = 3.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ld_vld, input, 1: load request.
REQ-006 SHALL have port ld_rdy, output, 1: load accepted when ld_vld & ld_rdy are both high at a clock edge.
REQ-007 SHALL have port ld_d, input, 4*DW: load value; digit k is ld_d[4k+3:4k], and one-hot bit i means digit value i.
REQ-008 SHALL have port dec, input, 1: decrement-by-one request.
REQ-009 SHALL have port rel, input, 1: release the count and return to EMPTY.
REQ-010 SHALL have port d_o, output, 4*DW: registered count, with the same encoding as ld_d.
REQ-011 SHALL have port zero, output, 1: the count is loaded and all digits equal 0.
REQ-012 SHALL have port nzero, output, 1: the count is loaded and at least one digit is non-zero.
REQ-013 SHALL have port uflow, output, 1: one-cycle pulse on a decrement at zero.
REQ-014 SHALL have port err, output, 1: one-cycle pulse when a malformed load is rejected.

Function
REQ-015 SHALL implement a two-state FSM, EMPTY and ACTIVE; ld_rdy = (state == EMPTY).
REQ-016 In EMPTY, d_o SHALL be all 4'b0000 (spacer), zero = 0 and nzero = 0; dec and rel are ignored.
REQ-017 EMPTY -> ACTIVE on an accepted load; d_o = ld_d from the next cycle, so load-to-output latency is 1 cycle.
REQ-018 In ACTIVE with dec=1, rel=0: digit 0 SHALL rotate down one code (bit i -> bit i-1, bit 0 -> bit 3).
REQ-019 Digit k>0 SHALL rotate the same way only when all lower digits are 0 (borrow chain); otherwise it holds.
REQ-020 Decrement at zero with WRAP=0: d_o SHALL hold all-0 and uflow pulses for 1 cycle.
REQ-021 Decrement at zero with WRAP=1: d_o SHALL become all digits = 3 (4'b1000 each) and uflow pulses for 1 cycle.
REQ-022 ACTIVE -> EMPTY on rel=1; rel SHALL take priority over a simultaneous dec, with no uflow.
REQ-023 zero and nzero SHALL be decoded combinationally from registered state, and SHALL never be high together.
REQ-024 Only one decrement per cycle; decrement-to-output latency is 1 cycle.

Reset
REQ-025 On rst_n low, the block SHALL immediately enter EMPTY: d_o = 0, zero = 0, nzero = 0, uflow = 0, err = 0, ld_rdy = 1.
REQ-026 Reset asserted mid-count SHALL discard the count; no uflow or err pulse is produced on reset exit.

Configuration
REQ-027 With macro M1OF4_CODE_CHK_EN defined, an accepted load with any digit not exactly one-hot SHALL be consumed, leave the state EMPTY and pulse err for 1 cycle.
REQ-028 Without M1OF4_CODE_CHK_EN, err SHALL be tied 0 and ld_d loaded unchecked; behaviour on malformed digits is undefined.

Structure
REQ-029 The shared package SHALL hold the 1-of-4 code constants (C0=4'b0001, C1=4'b0010, C2=4'b0100, C3=4'b1000), the FSM state typedef, and a digit typedef of 4 bits.
REQ-030 The design SHALL use one sub-module, m1of4_dig: a single-digit rotate with borrow-in, borrow-out and a one-hot check, instantiated DW times.

Verification
REQ-031 With DW=2, load {C2,C1} (value 9), then dec x2 -> d_o = {C2,C0} and then {C1,C3}; nzero = 1 throughout.
REQ-032 With DW=2 and WRAP=0, load {C0,C1}, then dec x2 -> zero = 1, d_o = {C0,C0}, and uflow pulses on the 2nd dec only.
REQ-033 With DW=2 and WRAP=1, load {C0,C0}, then dec -> d_o = {C3,C3}, uflow = 1 for one cycle, nzero = 1.
REQ-034 In ACTIVE, assert rel and dec in the same cycle -> next cycle EMPTY, d_o = 0, ld_rdy = 1, uflow = 0.
REQ-035 With M1OF4_CODE_CHK_EN defined, load digit 4'b0110 -> err = 1 for one cycle, state stays EMPTY, and ld_rdy stays 1.
REQ-036 Assert rst_n low asynchronously mid-count -> outputs go to reset values before the next clk edge.
